// File: rtl/cam_pattern_gen.sv
// Camera-style test pattern source: VSYNC/HREF framing with a byte ramp or an
// MSB-first serialized 32-bit word counter on DATA_o.
module cam_pattern_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_BLANK  = 144,
  parameter int V_ACTIVE = 480,
  parameter int VF_CYC   = 16,
  parameter int VB_CYC   = 16,
  parameter int FCW      = 16
) (
  input  logic           PCLKI,
  input  logic           WBs_RST_i,
  input  logic           enable_i,
  input  logic           mode_i,
  output logic           VSYNC_o,
  output logic           HREF_o,
  output logic [7:0]     DATA_o,
  output logic           busy_o,
  output logic [FCW-1:0] frame_cnt_o
);

  localparam int M1   = (VF_CYC > H_ACTIVE) ? VF_CYC : H_ACTIVE;
  localparam int M2   = (H_BLANK > VB_CYC) ? H_BLANK : VB_CYC;
  localparam int CMAX = ((M1 > M2) ? M1 : M2) - 1;
  localparam int CW   = (CMAX > 0) ? $clog2(CMAX + 1) : 1;
  localparam int LW   = (V_ACTIVE > 1) ? $clog2(V_ACTIVE + 1) : 1;

  localparam logic [CW-1:0] VF_LAST = CW'(VF_CYC - 1);
  localparam logic [CW-1:0] HA_LAST = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] HB_LAST = CW'(H_BLANK - 1);
  localparam logic [CW-1:0] VB_LAST = CW'(VB_CYC - 1);
  localparam logic [LW-1:0] LN_LAST = LW'(V_ACTIVE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_VFRONT, S_ACTIVE, S_HBLANK, S_VBACK
  } state_t;

  state_t          r_state;
  state_t          w_nxt;
  logic [CW-1:0]   r_cyc;
  logic [LW-1:0]   r_line;
  logic            r_mode;
  logic [7:0]      r_bcnt;
  logic [31:0]     r_word;
  logic [1:0]      r_phase;
  logic [7:0]      w_wbyte;
  logic [7:0]      w_byte;
  logic            w_frame_start;
  logic            w_frame_end;
  logic            w_line_end;

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:   if (enable_i) w_nxt = S_VFRONT;
      S_VFRONT: if (r_cyc == VF_LAST) w_nxt = S_ACTIVE;
      S_ACTIVE: if (r_cyc == HA_LAST) w_nxt = S_HBLANK;
      S_HBLANK: if (r_cyc == HB_LAST) w_nxt = (r_line == LN_LAST) ? S_VBACK : S_ACTIVE;
      S_VBACK:  if (r_cyc == VB_LAST) w_nxt = enable_i ? S_VFRONT : S_IDLE;
      default:  w_nxt = S_IDLE;
    endcase
  end

  assign w_frame_start = (w_nxt == S_VFRONT) && (r_state != S_VFRONT);
  assign w_frame_end   = (r_state == S_VBACK) && (r_cyc == VB_LAST);
  assign w_line_end    = (r_state == S_HBLANK) && (r_cyc == HB_LAST);

  always_comb begin
    w_wbyte = '0;
    case (r_phase)
      2'd0:    w_wbyte = r_word[31:24];
      2'd1:    w_wbyte = r_word[23:16];
      2'd2:    w_wbyte = r_word[15:8];
      default: w_wbyte = r_word[7:0];
    endcase
  end

  assign w_byte = r_mode ? w_wbyte : r_bcnt;

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge PCLKI or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      r_state     <= S_IDLE;
      r_cyc       <= '0;
      r_line      <= '0;
      r_mode      <= 1'b0;
      r_bcnt      <= '0;
      r_word      <= '0;
      r_phase     <= '0;
      VSYNC_o     <= 1'b0;
      HREF_o      <= 1'b0;
      DATA_o      <= '0;
      busy_o      <= 1'b0;
      frame_cnt_o <= '0;
    end else begin
      r_state <= w_nxt;
      if ((w_nxt != r_state) || (r_state == S_IDLE)) r_cyc <= '0;
      else                                           r_cyc <= r_cyc + CW'(1);

      if (w_frame_start) begin
        r_mode  <= mode_i;
        r_line  <= '0;
        r_bcnt  <= '0;
        r_word  <= '0;
        r_phase <= '0;
      end else begin
        if (w_line_end) r_line <= r_line + LW'(1);
        if (w_nxt == S_ACTIVE) begin
          if (r_mode) begin
            r_phase <= r_phase + 2'd1;
            if (r_phase == 2'd3) r_word <= r_word + 32'd1;
          end else begin
            r_bcnt <= r_bcnt + 8'd1;
          end
        end
      end

      VSYNC_o <= (w_nxt == S_ACTIVE) || (w_nxt == S_HBLANK);
      HREF_o  <= (w_nxt == S_ACTIVE);
      DATA_o  <= (w_nxt == S_ACTIVE) ? w_byte : 8'h00;
      busy_o  <= (w_nxt != S_IDLE);
      if (w_frame_end) frame_cnt_o <= frame_cnt_o + FCW'(1);
    end
  end

endmodule

// File: tb/tb_cam_pattern_gen.sv
// Bench for cam_pattern_gen: frame-offset arithmetic model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_cam_pattern_gen;
  localparam int HA = 8, HB = 4, VA = 2, VF = 3, VB = 2, FCW = 2;
  localparam int LINE = HA + HB;
  localparam int PERIOD = VF + VA * LINE + VB;

  logic           clk = 1'b0, rst = 1'b1, en = 1'b0, mode = 1'b0;
  logic           vsync, href, busy;
  logic [7:0]     data;
  logic [FCW-1:0] fcnt;

  cam_pattern_gen #(.H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA),
                    .VF_CYC(VF), .VB_CYC(VB), .FCW(FCW)) dut (
    .PCLKI(clk), .WBs_RST_i(rst), .enable_i(en), .mode_i(mode),
    .VSYNC_o(vsync), .HREF_o(href), .DATA_o(data), .busy_o(busy),
    .frame_cnt_o(fcnt));

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // model state: position within the current frame
  bit             m_busy = 0, m_mode = 0;
  int             m_off = 0;
  logic [FCW-1:0] m_fcnt = '0;

  int             cyc = 0, busy_cycles = 0, busy_falls = 0;
  bit             prev_vs = 0, prev_busy = 0;
  logic [FCW-1:0] prev_fcnt = '0;
  int             vs_rise[$];
  logic [7:0]     q_data[$];
  logic [FCW-1:0] q_fcnt[$];

  function automatic void clr();
    vs_rise.delete(); q_data.delete(); q_fcnt.delete();
    busy_cycles = 0; busy_falls = 0;
  endfunction

  always @(posedge clk) begin
    int ev, eh, ed, r, col, ln, n;
    if (rst) begin
      m_busy = 0; m_off = 0; m_mode = 0; m_fcnt = '0;
    end else if (!m_busy) begin
      if (en) begin m_busy = 1; m_off = 0; m_mode = mode; end
    end else if (m_off == PERIOD - 1) begin
      m_fcnt = m_fcnt + 1'b1;
      if (en) begin m_off = 0; m_mode = mode; end
      else m_busy = 0;
    end else begin
      m_off++;
    end
    #1;
    cyc++;
    ev = 0; eh = 0; ed = 0;
    if (m_busy && m_off >= VF && m_off < VF + VA * LINE) begin
      r = m_off - VF; ln = r / LINE; col = r % LINE;
      ev = 1;
      if (col < HA) begin
        eh = 1;
        n = ln * HA + col;
        ed = m_mode ? (((n / 4) >> (8 * (3 - n % 4))) & 255) : (n & 255);
      end
    end
    check("vsync", 32'(vsync), 32'(ev));
    check("href", 32'(href), 32'(eh));
    check("data", 32'(data), 32'(ed));
    check("busy", 32'(busy), 32'(m_busy));
    check("frame_cnt", 32'(fcnt), 32'(m_fcnt));
    if (busy) busy_cycles++;
    if (!busy && prev_busy) busy_falls++;
    if (vsync && !prev_vs) vs_rise.push_back(cyc);
    if (href) q_data.push_back(data);
    if (fcnt != prev_fcnt) q_fcnt.push_back(fcnt);
    prev_vs = vsync; prev_busy = busy; prev_fcnt = fcnt;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [7:0]     e1[16] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
                               8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h03};
    logic [FCW-1:0] ef[5]  = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    // reset and idle
    cycles(3);
    check("rst_outs", 32'({vsync, href, busy, data, fcnt}), 32'd0);
    rst = 1'b0; clr();
    cycles(10);
    check("idle_busy_cycles", busy_cycles, 0);
    check("idle_outs", 32'({vsync, href, busy, data, fcnt}), 32'd0);

    // single frame, mode 0
    clr(); mode = 1'b0; en = 1'b1; cycles(1); en = 1'b0; cycles(40);
    check("m0_busy_cycles", busy_cycles, 29);
    check("m0_nbytes", q_data.size(), 16);
    for (int i = 0; i < 16; i++)
      check("m0_byte", (i < q_data.size()) ? 32'(q_data[i]) : 32'hDEAD, i);
    check("m0_vs_rises", vs_rise.size(), 1);
    check("m0_fcnt", 32'(fcnt), 1);

    // single frame, mode 1; mode_i changes after the frame starts
    clr(); mode = 1'b1; en = 1'b1; cycles(1); en = 1'b0; mode = 1'b0; cycles(40);
    check("m1_nbytes", q_data.size(), 16);
    for (int i = 0; i < 16; i++)
      check("m1_byte", (i < q_data.size()) ? 32'(q_data[i]) : 32'hDEAD, 32'(e1[i]));
    check("m1_fcnt", 32'(fcnt), 2);

    // five back-to-back frames
    rst = 1'b1; cycles(1); rst = 1'b0; clr();
    en = 1'b1; cycles(4 * PERIOD + 10); en = 1'b0; cycles(40);
    check("b2b_vs_rises", vs_rise.size(), 5);
    for (int i = 1; i < 5; i++)
      check("b2b_period", (i < vs_rise.size()) ? vs_rise[i] - vs_rise[i-1] : -1, PERIOD);
    check("b2b_nfcnt", q_fcnt.size(), 5);
    for (int i = 0; i < 5; i++)
      check("b2b_fcnt_seq", (i < q_fcnt.size()) ? 32'(q_fcnt[i]) : 32'hDEAD, 32'(ef[i]));
    check("b2b_busy_falls", busy_falls, 1);
    check("b2b_busy_cycles", busy_cycles, 5 * PERIOD);

    // enable dropped during line 0: frame completes, then idle
    clr(); en = 1'b1; cycles(8); en = 1'b0; cycles(40);
    check("mid_en_busy_cycles", busy_cycles, 29);
    check("mid_en_idle", 32'(busy), 0);
    check("mid_en_fcnt", 32'(fcnt), 2);

    // reset during line 1 aborts the frame
    clr(); en = 1'b1; cycles(1); en = 1'b0; cycles(17);
    check("pre_rst_href", 32'(href), 1);
    rst = 1'b1; #1;
    check("mid_rst_outs", 32'({vsync, href, busy, data, fcnt}), 32'd0);
    cycles(1); rst = 1'b0; clr();
    en = 1'b1; cycles(1); en = 1'b0; cycles(40);
    check("post_rst_nbytes", q_data.size(), 16);
    for (int i = 0; i < 16; i++)
      check("post_rst_byte", (i < q_data.size()) ? 32'(q_data[i]) : 32'hDEAD, i);
    check("post_rst_fcnt", 32'(fcnt), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
